// File: rtl/maze_tile_renderer.sv
// Maze pixel renderer: tile lookup, checkpoint colouring, visit tracking
// and a timed red hit flash, delivered as a 2-stage registered pixel.
module maze_tile_renderer #(
    parameter int TILE        = 5,
    parameter int COLS        = 18,
    parameter int ROWS        = 11,
    parameter int X0          = 0,
    parameter int Y0          = 9,
    parameter int NCP         = 5,
    parameter int FLASH_HALF  = 16,
    parameter int FLASH_COUNT = 3,
    localparam int TW         = $clog2(COLS*ROWS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [6:0]          x,
    input  logic [5:0]          y,
    input  logic [COLS*ROWS-1:0] maze,
    input  logic [NCP*TW-1:0]   cp_tiles,
    input  logic [NCP*16-1:0]   cp_colors,
    input  logic [TW-1:0]       player_tile,
    input  logic                player_valid,
    input  logic                hit,
    input  logic                clear_visits,
    input  logic [15:0]         mask,
    output logic [15:0]         pixel,
    output logic                flashing,
    output logic [NCP-1:0]      visited,
    output logic                all_visited
);

    localparam int NT  = COLS*ROWS;
    localparam int TMW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int PW  = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
    localparam logic [TMW-1:0] RELOAD = TMW'(FLASH_HALF-1);
    localparam logic [PW-1:0]  LASTP  = PW'(FLASH_COUNT-1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

    state_e          state_q, state_d;
    logic [TMW-1:0]  tmr_q, tmr_d;
    logic [PW-1:0]   pr_q, pr_d;
    logic            flash_q;
    logic [NCP-1:0]  vis_q, vis_d;
    logic            ing_q, mbit_q;
    logic [TW-1:0]   tile_q;
    logic [15:0]     mask_q;
    logic [15:0]     pix_q, pix_d;

    int              xs, ys, tidx;
    logic            in_grid, mbit, pl_path;
    logic [TW-1:0]   tile;
    logic [15:0]     col;

    // Signed offsets keep the lower-edge test free of unsigned wrap.
    always_comb begin
        xs      = int'(x) - X0;
        ys      = int'(y) - Y0;
        in_grid = (xs >= 0) && (xs < COLS*TILE) &&
                  (ys >= 0) && (ys < ROWS*TILE);
        tidx    = (xs / TILE) + COLS * (ys / TILE);
        tile    = tidx[TW-1:0];
        mbit    = in_grid && maze[tile];
    end

    always_comb begin
        col = 16'hFFFF;
        for (int i = NCP-1; i >= 0; i--) begin
            if (tile_q == cp_tiles[i*TW +: TW])
                col = vis_q[i] ? 16'h7BEF : cp_colors[i*16 +: 16];
        end
        if (state_q == S_ON) col = 16'hFB30;
        if (!ing_q || !mbit_q) col = 16'h0000;
        pix_d = col & mask_q;
    end

    always_comb begin
        pl_path = ({1'b0, player_tile} < (TW+1)'(NT)) && maze[player_tile];
        vis_d   = vis_q;
        if (clear_visits) begin
            vis_d = '0;
        end else begin
            for (int i = 0; i < NCP; i++) begin
                if (player_valid && pl_path &&
                    player_tile == cp_tiles[i*TW +: TW])
                    vis_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pr_d    = pr_q;
        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_ON;
                    tmr_d   = RELOAD;
                    pr_d    = '0;
                end
            end
            S_ON: begin
                if (hit) begin
                    tmr_d = RELOAD;
                    pr_d  = '0;
                end else if (tmr_q == '0) begin
                    state_d = S_OFF;
                    tmr_d   = RELOAD;
                end else begin
                    tmr_d = tmr_q - TMW'(1);
                end
            end
            S_OFF: begin
                if (hit) begin
                    state_d = S_ON;
                    tmr_d   = RELOAD;
                    pr_d    = '0;
                end else if (tmr_q == '0) begin
                    if (pr_q == LASTP) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ON;
                        pr_d    = pr_q + PW'(1);
                        tmr_d   = RELOAD;
                    end
                end else begin
                    tmr_d = tmr_q - TMW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            pr_q    <= '0;
            flash_q <= 1'b0;
            vis_q   <= '0;
            ing_q   <= 1'b0;
            mbit_q  <= 1'b0;
            tile_q  <= '0;
            mask_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pr_q    <= pr_d;
            flash_q <= (state_d != S_IDLE);
            vis_q   <= vis_d;
            ing_q   <= in_grid;
            mbit_q  <= mbit;
            tile_q  <= tile;
            mask_q  <= mask;
            pix_q   <= pix_d;
        end
    end

    assign pixel       = pix_q;
    assign flashing    = flash_q;
    assign visited     = vis_q;
    assign all_visited = &vis_q;

endmodule

// File: doc/maze_tile_renderer.md
# maze_tile_renderer

Parametrised maze pixel renderer for the 96x64 OLED. It maps the current (x, y) scan coordinate onto a tile grid and looks up the wall/path bit. It colours checkpoints, tracks which checkpoints the player has visited, and plays a timed red "hit" flash sequence. Output is a 2-stage registered pixel that drives the OLED colour mux, combined with the caller-supplied overlay mask.

## Interface
Parameters:
- TILE, 5, tile edge in pixels
- COLS, 18, grid columns
- ROWS, 11, grid rows
- X0, 0, grid left edge (pixels)
- Y0, 9, grid top edge (pixels)
- NCP, 5, number of checkpoints
- FLASH_HALF, 16, cycles per flash ON or OFF half-period (≥1)
- FLASH_COUNT, 3, ON/OFF pairs per hit (≥1)
- Derived: TW = clog2(COLS*ROWS); default 8

Ports:
- CLK  in  1  pixel-domain clock
- RESET  in  1  asynchronous, active-high reset
- x  in  7  scan column
- y  in  6  scan row
- maze  in  COLS*ROWS  bit t=1 means tile t is path; t = col + COLS*row
- cp_tiles  in  NCP*TW  tile index of checkpoint i at bits [i*TW +: TW]
- cp_colors  in  NCP*16  RGB565 colour of checkpoint i
- player_tile  in  TW  tile the player occupies
- player_valid  in  1  player_tile is meaningful this cycle
- hit  in  1  single-cycle pulse; starts/restarts the flash sequence
- clear_visits  in  1  clears all visited flags
- mask  in  16  overlay mask ANDed into the pixel
- pixel  out  16  RGB565 output (registered)
- flashing  out  1  flash sequence active (registered)
- visited  out  NCP  per-checkpoint visited flags (registered)
- all_visited  out  1  AND of visited (combinational from registers)

## Operation
- Grid test: in_grid = x≥X0 & x<X0+COLS*TILE & y≥Y0 & y<Y0+ROWS*TILE. Compare at ≥9 bits; no wrap.
- Tile index: (x−X0)/TILE + COLS*((y−Y0)/TILE), truncated to TW bits. Only used when in_grid.
- Pipeline stage 1 registers in_grid, the tile index, the maze bit at that index, and mask.
- Stage 2 selects the colour in priority order:
  - outside grid or maze bit 0 → 16'h0000
  - flash state ON → 16'hFB30
  - tile equals cp_tiles[i] (lowest i wins): if visited[i], 16'h7BEF; otherwise cp_colors[i]
  - otherwise → 16'hFFFF
- Stage 2 output: pixel = colour & mask(stage 1).
- Flash FSM has states IDLE, ON, OFF, a half-period timer, and a pair counter.
  - IDLE + hit → ON; timer = FLASH_HALF−1; pairs = 0.
  - ON, timer = 0 → OFF; timer reloads.
  - OFF, timer = 0 → if pairs = FLASH_COUNT−1, go to IDLE; otherwise go to ON, pairs+1, timer reloads.
  - Otherwise the timer decrements.
  - hit in ON or OFF restarts the sequence: ON, timer reload, pairs = 0.
- flashing = 1 in ON and OFF.
- Visit tracker, per cycle: if clear_visits, visited = 0. Otherwise, for each i, if player_valid & player_tile == cp_tiles[i] & maze[player_tile], set visited[i]. Set flags stay set.
- When clear_visits and a set condition occur in the same cycle, clear wins.
- Reset values: pixel = 0, flashing = 0, visited = 0, FSM = IDLE, timer/pairs = 0, pipeline registers = 0 (in_grid = 0).
- RESET asserted mid-operation forces all registers to their reset values immediately, independent of CLK.

## Timing
- Pixel latency: 2 CLK cycles from x/y/mask to pixel. Throughput is 1 pixel per cycle.
- Stage 2 uses the FSM state and visited flags as registered at that edge.
- hit sampled at edge n → flashing = 1 after edge n. The ON window lasts FLASH_HALF cycles, then the OFF window lasts FLASH_HALF cycles.
- A full sequence lasts 2*FLASH_HALF*FLASH_COUNT cycles. flashing falls at edge n + 2*FLASH_HALF*FLASH_COUNT.
- Visit set/clear takes effect 1 cycle after the sampling edge. A pixel at that checkpoint turns grey starting 1 cycle later in stage 2.

## Test plan
- Defaults; maze all 1s; cp_tiles[0]=31, cp_colors[0]=FC0D; mask=FFFF; x=65, y=14 → pixel=FC0D two cycles later. x=0, y=9 → FFFF. x=92, y=20 → 0000. y=8 → 0000.
- maze bit 31 = 0; same coordinate → 0000, even while flashing. mask=F800 on a path pixel → F800.
- player_tile=31, player_valid=1 for one cycle → visited=00001 next cycle, and pixel at (65,14) becomes 7BEF. Setting all 5 checkpoints → all_visited=1. clear_visits and player_valid on tile 31 in the same cycle → visited stays 0.
- FLASH_HALF=4, FLASH_COUNT=2; hit at edge n:
  - flashing high from n+1 through n+16
  - path pixel FB30 for cycles n+1..n+4 and n+9..n+12, and FFFF in the OFF windows (subject to 2-cycle pipeline)
  - second hit at n+6 extends flashing to n+22
- RESET pulsed mid-flash with visited≠0 → pixel, flashing and visited read 0 immediately. After release, the sequence stays IDLE until the next hit.
